// File: rtl/dig_pkg.sv
// Shared constants for the keypad price-entry encoder: key codes, state encoding, limits.
// The optional echo display port is enabled by defining DIG_ENC_ECHO_EN.
package dig_pkg;

    localparam logic [3:0] KEY_POINT = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hC;

    localparam int AMT_W         = 6;
    localparam int DIG_POINT_BIT = 9;

    localparam logic [6:0]  INT_MAX  = 7'd31;
    localparam logic [14:0] DIG_IDLE = 15'h0200;

    // Bit 0 of the state is "entry in progress", bit 2 is "error", so busy/err are plain flop bits.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_INT  = 3'b001,
        ST_FRAC = 3'b011,
        ST_ERR  = 3'b100
    } state_t;

endpackage

// File: rtl/dig_enc_bcd2bin.sv
// Two-digit BCD to binary conversion used when an entered amount is committed.
module bcd2bin (
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [6:0] bin
);

    assign bin = ({3'b000, tens} * 7'd10) + {3'b000, ones};

endmodule

// File: rtl/dig_enc.sv
// Keypad price-entry encoder: assembles TT.F from keystrokes and commits it as half-units.
// Defining DIG_ENC_ECHO_EN adds the dig echo display port.
module dig_enc
    import dig_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic [AMT_W-1:0] amount,
    output logic             amount_valid,
    output logic             busy,
    output logic             err
`ifdef DIG_ENC_ECHO_EN
    ,
    output logic [14:0]      dig
`endif
);

    // key_code is consumed only on an edge where key_valid is 1; there is no backpressure,
    // so a strobe is accepted every cycle it is asserted.

    state_t     state;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       half;
    logic [1:0] ndig;
    logic       fdig;
    logic [6:0] int_val;
    logic       is_digit;

    bcd2bin u_bcd2bin (
        .tens (tens),
        .ones (ones),
        .bin  (int_val)
    );

    assign is_digit = (key_code <= 4'd9);
    assign busy     = state[0];
    assign err      = state[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            tens         <= 4'd0;
            ones         <= 4'd0;
            half         <= 1'b0;
            ndig         <= 2'd0;
            fdig         <= 1'b0;
            amount       <= '0;
            amount_valid <= 1'b0;
        end else begin
            amount_valid <= 1'b0;
            if (key_valid) begin
                if (key_code == KEY_CLEAR) begin
                    state <= ST_IDLE;
                    tens  <= 4'd0;
                    ones  <= 4'd0;
                    half  <= 1'b0;
                    ndig  <= 2'd0;
                    fdig  <= 1'b0;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (is_digit) begin
                                ones  <= key_code;
                                ndig  <= 2'd1;
                                state <= ST_INT;
                            end else if (key_code == KEY_POINT) begin
                                tens  <= 4'd0;
                                ones  <= 4'd0;
                                state <= ST_FRAC;
                            end
                        end
                        ST_INT, ST_FRAC: begin
                            if (is_digit) begin
                                if (state == ST_INT && ndig == 2'd1) begin
                                    tens <= ones;
                                    ones <= key_code;
                                    ndig <= 2'd2;
                                end else if (state == ST_FRAC && !fdig &&
                                             (key_code == 4'd0 || key_code == 4'd5)) begin
                                    half <= (key_code == 4'd5);
                                    fdig <= 1'b1;
                                end else begin
                                    state <= ST_ERR;
                                end
                            end else if (key_code == KEY_POINT) begin
                                state <= (state == ST_INT) ? ST_FRAC : ST_ERR;
                            end else if (key_code == KEY_ENTER) begin
                                // Out-of-range totals lock into error; amount keeps its old value.
                                if (int_val > INT_MAX) begin
                                    state <= ST_ERR;
                                end else begin
                                    amount       <= {int_val[4:0], half};
                                    amount_valid <= 1'b1;
                                    state        <= ST_IDLE;
                                    tens         <= 4'd0;
                                    ones         <= 4'd0;
                                    half         <= 1'b0;
                                    ndig         <= 2'd0;
                                    fdig         <= 1'b0;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef DIG_ENC_ECHO_EN
    always_comb begin
        dig                = '0;
        dig[13:10]         = tens;
        dig[DIG_POINT_BIT] = 1'b1;
        dig[8:5]           = ones;
        dig[3:0]           = half ? 4'b0101 : 4'b0000;
    end
`endif

endmodule

// File: tb/tb_dig_enc.sv
// Directed self-checking bench for dig_enc with a scoreboard of expected committed amounts.
// Echo checks are compiled in when DIG_ENC_ECHO_EN is defined.
module tb_dig_enc;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic [5:0] amount;
    logic       amount_valid;
    logic       busy;
    logic       err;
`ifdef DIG_ENC_ECHO_EN
    logic [14:0] dig;
`endif

    logic [5:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dig_enc dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .amount       (amount),
        .amount_valid (amount_valid),
        .busy         (busy),
        .err          (err)
`ifdef DIG_ENC_ECHO_EN
        ,
        .dig          (dig)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_dig(input string tag, input logic [14:0] exp);
`ifdef DIG_ENC_ECHO_EN
        check(tag, {17'd0, dig}, {17'd0, exp});
`endif
    endtask

    // One strobe, then one idle cycle; returns at 1 time unit after the sampling edge.
    task automatic press(input logic [3:0] k);
        @(posedge clk);
        #1;
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic press_seq(input logic [3:0] k0, input logic [3:0] k1,
                             input logic [3:0] k2, input logic [3:0] k3, input int n);
        if (n > 0) press(k0);
        if (n > 1) press(k1);
        if (n > 2) press(k2);
        if (n > 3) press(k3);
    endtask

    // Scoreboard: every amount_valid pulse must match the oldest expected commit.
    always @(negedge clk) begin
        if (!rst && amount_valid === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_pulse", {26'd0, amount}, 32'hFFFF_FFFF);
            else check("sb_amount", {26'd0, amount}, {26'd0, exp_q.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_code = 4'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_amount", {26'd0, amount}, 32'd0);
        check("rst_valid", {31'd0, amount_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check_dig("rst_dig", 15'h0200);

        // 12.5 -> 25
        press_seq(4'd1, 4'd2, 0, 0, 2);
        check("busy_int", {31'd0, busy}, 32'd1);
        check_dig("dig_12", 15'h0640);
        press_seq(4'hA, 4'd5, 0, 0, 2);
        check("busy_frac", {31'd0, busy}, 32'd1);
        check_dig("dig_12_5", 15'h0645);
        exp_q.push_back(6'd25);
        press(4'hC);
        check("amt_25", {26'd0, amount}, 32'd25);
        check("busy_after_commit", {31'd0, busy}, 32'd0);
        check_dig("dig_after_commit", 15'h0200);

        exp_q.push_back(6'd1);
        press_seq(4'hA, 4'd5, 4'hC, 0, 3);
        check("amt_0_5", {26'd0, amount}, 32'd1);
        exp_q.push_back(6'd14);
        press_seq(4'd7, 4'hC, 0, 0, 2);
        check("amt_7", {26'd0, amount}, 32'd14);
        exp_q.push_back(6'd6);
        press_seq(4'd3, 4'hA, 4'd0, 4'hC, 4);
        check("amt_3_0", {26'd0, amount}, 32'd6);

        // 32 out of range
        press_seq(4'd3, 4'd2, 4'hC, 0, 3);
        check("err_32", {31'd0, err}, 32'd1);
        check("amt_hold", {26'd0, amount}, 32'd6);
        press(4'hB);
        check("clr_err", {31'd0, err}, 32'd0);
        check("clr_busy", {31'd0, busy}, 32'd0);
        check_dig("clr_dig", 15'h0200);

        press_seq(4'd4, 4'hA, 4'd3, 0, 3);
        check("err_frac3", {31'd0, err}, 32'd1);
        press(4'hC);
        check("err_sticky", {31'd0, err}, 32'd1);
        press(4'hB);
        press_seq(4'd1, 4'd2, 4'd3, 0, 3);
        check("err_3dig", {31'd0, err}, 32'd1);
        press(4'hB);
        press_seq(4'd9, 4'hA, 4'd5, 4'd5, 4);
        check("err_2frac", {31'd0, err}, 32'd1);
        press(4'hB);
        press_seq(4'hA, 4'hA, 0, 0, 2);
        check("err_2point", {31'd0, err}, 32'd1);
        press(4'hB);

        press(4'hE);
        check("ign_busy", {31'd0, busy}, 32'd0);
        check("ign_err", {31'd0, err}, 32'd0);

        // Upper boundary 31.5 -> 63
        press_seq(4'd3, 4'd1, 4'hA, 4'd5, 4);
        exp_q.push_back(6'd63);
        press(4'hC);
        check("amt_63", {26'd0, amount}, 32'd63);
        press(4'hC);
        check("idle_enter_valid", {31'd0, amount_valid}, 32'd0);
        check("idle_enter_amt", {26'd0, amount}, 32'd63);

        // Back-to-back strobes across a commit
        @(posedge clk); #1 key_valid = 1'b1; key_code = 4'd8;
        @(posedge clk); #1 key_code = 4'hC; exp_q.push_back(6'd16);
        @(posedge clk); #1 key_code = 4'd4;
        check("b2b_amt", {26'd0, amount}, 32'd16);
        @(posedge clk); #1 key_valid = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_valid_drop", {31'd0, amount_valid}, 32'd0);
        exp_q.push_back(6'd8);
        press(4'hC);
        check("b2b_second", {26'd0, amount}, 32'd8);

        // Reset wins over a coincident strobe
        press(4'd2);
        @(posedge clk); #1 rst = 1'b1; key_valid = 1'b1; key_code = 4'd5;
        @(posedge clk); #1 rst = 1'b0; key_valid = 1'b0;
        check("mid_rst_amt", {26'd0, amount}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        check("mid_rst_valid", {31'd0, amount_valid}, 32'd0);
        check_dig("mid_rst_dig", 15'h0200);
        exp_q.push_back(6'd10);
        press_seq(4'd5, 4'hC, 0, 0, 2);
        check("amt_after_rst", {26'd0, amount}, 32'd10);

        repeat (3) @(posedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
